// File: rtl/pp_pkg.sv
// Shared types, constants and pixel arithmetic for the output post-processing pipeline.
package pp_pkg;

  localparam int MAX_BITS = 16;

  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_H   = 2'd1;
  localparam logic [1:0] SL_V   = 2'd2;
  localparam logic [1:0] SL_HV  = 2'd3;

  typedef logic [MAX_BITS-1:0] px_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  typedef struct packed {
    sync_t      sync;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [2:0]  line_id;
    logic [2:0]  col_id;
  } ctrl_t;

  typedef struct packed {
    logic [1:0]  sl_mode;
    logic [7:0]  lmask;
    logic [7:0]  cmask;
    logic [3:0]  mask_br;
    logic [10:0] h_start;
    logic [10:0] h_end;
    logic [10:0] v_start;
    logic [10:0] v_end;
  } cfg_t;

  // Power-on shadow: scanlines off and a window covering the whole raster.
  localparam cfg_t CFG_RST = '{
    sl_mode: SL_OFF,
    lmask:   8'h00,
    cmask:   8'h00,
    mask_br: 4'h0,
    h_start: 11'd0,
    h_end:   11'd2047,
    v_start: 11'd0,
    v_end:   11'd2047
  };

  // Input lands in the MSBs; LSBs are zero or a cyclic repeat of the input from its MSB down.
  function automatic px_t expand_px(input px_t data, input int in_bits, input int out_bits,
                                    input bit expand);
    px_t res;
    int  k;
    res = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < out_bits) begin
        k = out_bits - 1 - i;
        if (k < in_bits) begin
          res[i] = data[in_bits-1-k];
        end else if (expand) begin
          res[i] = data[in_bits-1-(k % in_bits)];
        end
      end
    end
    return res;
  endfunction

  function automatic px_t sat_sub(input px_t data, input px_t str);
    return (data > str) ? data - str : '0;
  endfunction

  function automatic px_t sl_strength(input logic [3:0] str4, input int out_bits);
    return ((px_t'(str4) + px_t'(1)) << (out_bits - 4)) - px_t'(1);
  endfunction

endpackage

// File: rtl/pp_postproc_if.sv
// Video bus: one pixel of RGB plus its syncs and data enable.
interface pp_postproc_if #(
    parameter int W = 8
);
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic         hsync;
    logic         vsync;
    logic         de;

    modport master (output r, g, b, hsync, vsync, de);
    modport slave  (input  r, g, b, hsync, vsync, de);
endinterface

// File: rtl/pp_delay.sv
// Fixed-depth register delay line; DEPTH 0 collapses to a wire.
module pp_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             PCLK_out,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            // NOTE: every stage is reset so syncs leave reset at their inactive level
            // instead of flushing stale values out of an unreset shift register.
            always_ff @(posedge PCLK_out or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
                end else begin
                    // NOTE: non-blocking so each stage takes its neighbour's old value.
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pp_postproc.sv
// Output post-processing: bit expansion, scanlines and border mask, with
// configuration shadowed on the VSYNC leading edge.
module pp_postproc
    import pp_pkg::*;
#(
    parameter int IN_BITS  = 5,
    parameter int OUT_BITS = 8,
    parameter int DATA_DLY = 1,
    parameter bit EXPAND   = 1'b1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic          PCLK_out,
    input  logic          reset_n,
    pp_postproc_if.slave  vid_i,
    input  logic [10:0]   hcnt_i,
    input  logic [10:0]   vcnt_i,
    input  logic [2:0]    line_id_i,
    input  logic [2:0]    col_id_i,
    input  logic [1:0]    cfg_sl_mode_i,
    input  logic [3:0]    cfg_sl_str_i,
    input  logic [7:0]    cfg_sl_lmask_i,
    input  logic [7:0]    cfg_sl_cmask_i,
    input  logic [3:0]    cfg_mask_br_i,
    input  logic [10:0]   cfg_h_start_i,
    input  logic [10:0]   cfg_h_end_i,
    input  logic [10:0]   cfg_v_start_i,
    input  logic [10:0]   cfg_v_end_i,
    pp_postproc_if.master vid_o
);

    typedef logic [OUT_BITS-1:0]      opx_t;
    typedef logic [2:0][OUT_BITS-1:0] rgb_t;   // [2]=R [1]=G [0]=B

    localparam sync_t SYNC_RST = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0};
    localparam ctrl_t CTRL_RST = '{sync: SYNC_RST, default: '0};

    // ---------------- align stage ----------------
    ctrl_t ctrl_in;
    ctrl_t ctrl_a;

    assign ctrl_in = '{
        sync:    '{hsync: vid_i.hsync, vsync: vid_i.vsync, de: vid_i.de},
        hcnt:    hcnt_i,
        vcnt:    vcnt_i,
        line_id: line_id_i,
        col_id:  col_id_i
    };

    pp_delay #(
        .WIDTH  ($bits(ctrl_t)),
        .DEPTH  (DATA_DLY),
        .RST_VAL(CTRL_RST)
    ) u_align (
        .PCLK_out(PCLK_out),
        .reset_n (reset_n),
        .d_i     (ctrl_in),
        .q_o     (ctrl_a)
    );

    // ---------------- shadow configuration ----------------
    // Edge detection uses the raw VSYNC_in so the shadow flips before the
    // first pixel of the new frame reaches S1.
    logic vs_act;
    logic vs_edge;
    logic vs_prev_q;
    cfg_t cfg_d;
    cfg_t cfg_q;
    opx_t str_q;

    assign vs_act  = (vid_i.vsync == SYNC_POL);
    assign vs_edge = vs_act & ~vs_prev_q;

    assign cfg_d = '{
        sl_mode: cfg_sl_mode_i,
        lmask:   cfg_sl_lmask_i,
        cmask:   cfg_sl_cmask_i,
        mask_br: cfg_mask_br_i,
        h_start: cfg_h_start_i,
        h_end:   cfg_h_end_i,
        v_start: cfg_v_start_i,
        v_end:   cfg_v_end_i
    };

    always_ff @(posedge PCLK_out or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_q <= 1'b0;
            cfg_q     <= CFG_RST;
            str_q     <= opx_t'(sl_strength(4'd0, OUT_BITS));
        end else begin
            vs_prev_q <= vs_act;
            if (vs_edge) begin
                cfg_q <= cfg_d;
                str_q <= opx_t'(sl_strength(cfg_sl_str_i, OUT_BITS));
            end
        end
    end

    // ---------------- S1: expand, resolve darken and window ----------------
    // Config-dependent decisions are taken here and carried along, so a pixel
    // is processed entirely with the shadow it saw on entering S1.
    rgb_t  s1_px_d;
    logic  s1_dark_d;
    logic  s1_inwin_d;

    rgb_t  s1_px_q;
    sync_t s1_sync_q;
    logic  s1_dark_q;
    logic  s1_inwin_q;
    opx_t  s1_str_q;
    logic [3:0] s1_br_q;

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        s1_px_d    = '0;
        s1_px_d[2] = opx_t'(expand_px(px_t'(vid_i.r), IN_BITS, OUT_BITS, EXPAND));
        s1_px_d[1] = opx_t'(expand_px(px_t'(vid_i.g), IN_BITS, OUT_BITS, EXPAND));
        s1_px_d[0] = opx_t'(expand_px(px_t'(vid_i.b), IN_BITS, OUT_BITS, EXPAND));

        s1_dark_d = (cfg_q.sl_mode[0] & cfg_q.lmask[ctrl_a.line_id])
                  | (cfg_q.sl_mode[1] & cfg_q.cmask[ctrl_a.col_id]);

        // An empty or inverted window never matches, so everything is masked.
        s1_inwin_d = (ctrl_a.hcnt >= cfg_q.h_start) && (ctrl_a.hcnt < cfg_q.h_end)
                  && (ctrl_a.vcnt >= cfg_q.v_start) && (ctrl_a.vcnt < cfg_q.v_end);
    end

    always_ff @(posedge PCLK_out or negedge reset_n) begin
        if (!reset_n) begin
            s1_px_q    <= '0;
            s1_sync_q  <= SYNC_RST;
            s1_dark_q  <= 1'b0;
            s1_inwin_q <= 1'b0;
            s1_str_q   <= '0;
            s1_br_q    <= '0;
        end else begin
            s1_px_q    <= s1_px_d;
            s1_sync_q  <= ctrl_a.sync;
            s1_dark_q  <= s1_dark_d;
            s1_inwin_q <= s1_inwin_d;
            s1_str_q   <= str_q;
            s1_br_q    <= cfg_q.mask_br;
        end
    end

    // ---------------- S2: scanline darkening ----------------
    rgb_t  s2_px_d;
    rgb_t  s2_px_q;
    sync_t s2_sync_q;
    logic  s2_inwin_q;
    logic [3:0] s2_br_q;

    always_comb begin
        s2_px_d = s1_px_q;
        if (s1_dark_q) begin
            for (int c = 0; c < 3; c++) begin
                s2_px_d[c] = opx_t'(sat_sub(px_t'(s1_px_q[c]), px_t'(s1_str_q)));
            end
        end
    end

    always_ff @(posedge PCLK_out or negedge reset_n) begin
        if (!reset_n) begin
            s2_px_q    <= '0;
            s2_sync_q  <= SYNC_RST;
            s2_inwin_q <= 1'b0;
            s2_br_q    <= '0;
        end else begin
            s2_px_q    <= s2_px_d;
            s2_sync_q  <= s1_sync_q;
            s2_inwin_q <= s1_inwin_q;
            s2_br_q    <= s1_br_q;
        end
    end

    // ---------------- S3: blank and border mask ----------------
    rgb_t  out_px_d;
    opx_t  border_px;
    rgb_t  out_px_q;
    sync_t out_sync_q;

    assign border_px = opx_t'(opx_t'(s2_br_q) << (OUT_BITS - 4));

    always_comb begin
        out_px_d = '0;
        if (s2_sync_q.de) begin
            if (!s2_inwin_q) begin
                out_px_d = {3{border_px}};
            end else begin
                out_px_d = s2_px_q;
            end
        end
    end

    always_ff @(posedge PCLK_out or negedge reset_n) begin
        if (!reset_n) begin
            out_px_q   <= '0;
            out_sync_q <= SYNC_RST;
        end else begin
            out_px_q   <= out_px_d;
            out_sync_q <= s2_sync_q;
        end
    end

    assign vid_o.r     = out_px_q[2];
    assign vid_o.g     = out_px_q[1];
    assign vid_o.b     = out_px_q[0];
    assign vid_o.hsync = out_sync_q.hsync;
    assign vid_o.vsync = out_sync_q.vsync;
    assign vid_o.de    = out_sync_q.de;

endmodule
